// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants and state enum for the ALU self-check harness
package alu_pkg;

  localparam int DATA_W = 7;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_NAND = 2'b10;
  localparam logic [1:0] OP_ROL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// rtl/alu_ref_model.sv - combinational expected-result function of the 7-bit ALU
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_NAND: y = ~(a & b);
      OP_ROL:  y = {a[DATA_W-2:0], a[DATA_W-1]};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_result_checker.sv
// rtl/alu_result_checker.sv - aligns expected ALU results with Y and keeps pass/fail stats
// Optional first-fail capture ports: ALU_CHK_FIRST_FAIL_EN.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int ALU_LAT = 1,
  parameter int NUM_VEC = 6,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [1:0]        OP,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] Y,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              error,
  output logic              orphan_err,
  output logic              done,
  output logic              busy
`ifdef ALU_CHK_FIRST_FAIL_EN
  ,
  output logic              ff_valid,
  output logic [DATA_W-1:0] ff_exp,
  output logic [DATA_W-1:0] ff_got,
  output logic [CNT_W-1:0]  ff_idx
`endif
);

  localparam int ACC_W = $clog2(NUM_VEC + 1);

  chk_state_e         state_q, state_d;
  logic [ALU_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [DATA_W-1:0]  pipe_e_q [ALU_LAT];
  logic [DATA_W-1:0]  pipe_e_d [ALU_LAT];
  logic [ACC_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic               error_q, error_d;
  logic               orphan_q, orphan_d;

  logic [DATA_W-1:0]  exp_in;
  logic               accept, due, pending, hit;

  alu_ref_model u_ref (
    .a  (A),
    .b  (B),
    .op (OP),
    .y  (exp_in)
  );

  always_comb begin
    accept = in_valid && (state_q == ST_IDLE || state_q == ST_RUN);
    due    = pipe_v_q[ALU_LAT-1];
    hit    = due && res_valid && (Y == pipe_e_q[ALU_LAT-1]);
    // Other vectors still in flight; DRAIN may only finish on the last one.
    pending = 1'b0;
    for (int i = 0; i < ALU_LAT - 1; i++) pending = pending | pipe_v_q[i];

    pipe_v_d    = '0;
    pipe_e_d    = pipe_e_q;
    pipe_v_d[0] = accept;
    pipe_e_d[0] = exp_in;
    for (int i = 1; i < ALU_LAT; i++) begin
      pipe_v_d[i] = pipe_v_q[i-1];
      pipe_e_d[i] = pipe_e_q[i-1];
    end

    acc_cnt_d  = acc_cnt_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    error_d    = error_q;
    orphan_d   = orphan_q;
    if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
    if (due) begin
      if (hit) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
      end else begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        error_d = 1'b1;
      end
    end else if (res_valid) begin
      orphan_d = 1'b1;
      error_d  = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (accept)
          state_d = (acc_cnt_q == ACC_W'(NUM_VEC - 1)) ? ST_DRAIN : ST_RUN;
      end
      ST_DRAIN: if (due && !pending) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pipe_v_q   <= '0;
      acc_cnt_q  <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      error_q    <= 1'b0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pipe_v_q   <= pipe_v_d;
      acc_cnt_q  <= acc_cnt_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      error_q    <= error_d;
      orphan_q   <= orphan_d;
    end
  end

  // Expected values are qualified by pipe_v_q, so they need no reset.
  always_ff @(posedge clk) begin
    pipe_e_q <= pipe_e_d;
  end

  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign error      = error_q;
  assign orphan_err = orphan_q;
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);

`ifdef ALU_CHK_FIRST_FAIL_EN
  logic              ff_valid_q, ff_valid_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_got_q, ff_got_d;
  logic [CNT_W-1:0]  ff_idx_q, ff_idx_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;

  always_comb begin
    ff_valid_d = ff_valid_q;
    ff_exp_d   = ff_exp_q;
    ff_got_d   = ff_got_q;
    ff_idx_d   = ff_idx_q;
    res_cnt_d  = res_cnt_q;
    if (due) begin
      res_cnt_d = res_cnt_q + 1'b1;
      if (!hit && !ff_valid_q) begin
        ff_valid_d = 1'b1;
        ff_exp_d   = pipe_e_q[ALU_LAT-1];
        ff_got_d   = res_valid ? Y : '0;
        ff_idx_d   = res_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ff_valid_q <= 1'b0;
      ff_exp_q   <= '0;
      ff_got_q   <= '0;
      ff_idx_q   <= '0;
      res_cnt_q  <= '0;
    end else begin
      ff_valid_q <= ff_valid_d;
      ff_exp_q   <= ff_exp_d;
      ff_got_q   <= ff_got_d;
      ff_idx_q   <= ff_idx_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  assign ff_valid = ff_valid_q;
  assign ff_exp   = ff_exp_q;
  assign ff_got   = ff_got_q;
  assign ff_idx   = ff_idx_q;
`endif

endmodule

// File: tb/tb_alu_result_checker.sv
// tb/tb_alu_result_checker.sv - randomized self-checking bench for alu_result_checker
`timescale 1ns/1ps
module tb_alu_result_checker;

  localparam int LAT = 3;
  localparam int NV  = 6;
  localparam int CW  = 8;

  logic          clk = 1'b0;
  logic          rst, in_valid, res_valid;
  logic [6:0]    A, B, Y;
  logic [1:0]    OP;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic          error, orphan_err, done, busy;
`ifdef ALU_CHK_FIRST_FAIL_EN
  logic          ff_valid;
  logic [6:0]    ff_exp, ff_got;
  logic [CW-1:0] ff_idx;
`endif

  int checks   = 0;
  int failures = 0;

  // Scoreboard state for the current run (cleared by do_reset)
  int m_pass, m_fail;
  bit m_err, m_ffv;
  int m_ffe, m_ffg, m_ffi;

  logic [6:0] va [16];
  logic [6:0] vb [16];
  logic [1:0] vop [16];
  logic [6:0] vexp [16];
  logic [6:0] vgot [16];
  bit         vmiss [16];

  always #5 clk = ~clk;

  alu_result_checker #(.ALU_LAT(LAT), .NUM_VEC(NV), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .A          (A),
    .B          (B),
    .OP         (OP),
    .res_valid  (res_valid),
    .Y          (Y),
    .pass_cnt   (pass_cnt),
    .fail_cnt   (fail_cnt),
    .error      (error),
    .orphan_err (orphan_err),
    .done       (done),
    .busy       (busy)
`ifdef ALU_CHK_FIRST_FAIL_EN
    ,
    .ff_valid   (ff_valid),
    .ff_exp     (ff_exp),
    .ff_got     (ff_got),
    .ff_idx     (ff_idx)
`endif
  );

  function automatic int ref_exp(input int a, input int b, input int op);
    case (op)
      0:       return (a + b) % 128;
      1:       return (a - b + 128) % 128;
      2:       return 127 - (a & b);
      default: return ((a * 2) % 128) + (a / 64);
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; res_valid = 1'b0;
    A = '0; B = '0; OP = '0; Y = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pass = 0; m_fail = 0; m_err = 0; m_ffv = 0; m_ffe = 0; m_ffg = 0; m_ffi = 0;
  endtask

  task automatic set_vec(input int i, input int a, input int b, input int op,
                         input int got, input bit miss);
    va[i] = 7'(a); vb[i] = 7'(b); vop[i] = 2'(op);
    vexp[i] = 7'(ref_exp(a, b, op));
    vgot[i] = 7'(got); vmiss[i] = miss;
  endtask

  task automatic fill_random(input int n, input int pct_bad);
    int a, b, op, e, k;
    for (int i = 0; i < n; i++) begin
      a = $urandom_range(0, 127); b = $urandom_range(0, 127); op = $urandom_range(0, 3);
      e = ref_exp(a, b, op);
      k = $urandom_range(0, 99);
      if (k < pct_bad / 2)   set_vec(i, a, b, op, e, 1'b1);
      else if (k < pct_bad)  set_vec(i, a, b, op, e ^ $urandom_range(1, 127), 1'b0);
      else                   set_vec(i, a, b, op, e, 1'b0);
    end
  endtask

  // Issues n vectors (optionally with idle gaps), plays the ALU's role by
  // answering each one LAT cycles later, and checks the running score every edge.
  task automatic run(input int n, input bit gaps, input bit extra);
    int sched [64];
    int t, nxt, last_res, r;
    bit finished, done_exp, busy_exp;
    for (int i = 0; i < 64; i++) sched[i] = -1;
    nxt = 0; last_res = -1; finished = 0;
    for (t = 0; t < 60 && !finished; t++) begin
      if (nxt < n && (!gaps || $urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1; A = va[nxt]; B = vb[nxt]; OP = vop[nxt];
        sched[t + LAT] = nxt;
        if (nxt == n - 1) last_res = t + LAT;
        nxt++;
      end else if (extra && nxt >= n) begin
        in_valid = 1'b1; A = 7'($urandom); B = 7'($urandom); OP = 2'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      r = sched[t];
      res_valid = (r >= 0) && !vmiss[r];
      Y = (r >= 0 && !vmiss[r]) ? vgot[r] : 7'($urandom);
      @(posedge clk); #1;
      if (r >= 0) begin
        if (!vmiss[r] && vgot[r] == vexp[r]) m_pass++;
        else begin
          m_fail++; m_err = 1;
          if (!m_ffv) begin
            m_ffv = 1; m_ffe = int'(vexp[r]); m_ffg = vmiss[r] ? 0 : int'(vgot[r]); m_ffi = r;
          end
        end
      end
      finished = (last_res >= 0) && (t >= last_res);
      done_exp = (n == NV) && finished;
      busy_exp = (nxt > 0) && !done_exp;
      checks++;
      if (pass_cnt !== CW'(m_pass)) begin
        failures++; $display("FAIL run_pass_cnt t=%0d: got %0d expected %0d", t, pass_cnt, m_pass);
      end
      checks++;
      if (fail_cnt !== CW'(m_fail)) begin
        failures++; $display("FAIL run_fail_cnt t=%0d: got %0d expected %0d", t, fail_cnt, m_fail);
      end
      checks++;
      if (error !== m_err || orphan_err !== 1'b0) begin
        failures++; $display("FAIL run_flags t=%0d: error=%b orphan=%b expected error=%b orphan=0", t, error, orphan_err, m_err);
      end
      checks++;
      if (done !== done_exp || busy !== busy_exp) begin
        failures++; $display("FAIL run_done_busy t=%0d: done=%b busy=%b expected done=%b busy=%b", t, done, busy, done_exp, busy_exp);
      end
    end
    checks++;
    if (!finished) begin
      failures++; $display("FAIL run_timeout: got unfinished expected all %0d vectors resolved", n);
    end
    in_valid = 1'b0; res_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (pass_cnt !== '0 || fail_cnt !== '0) begin
      failures++; $display("FAIL reset_counters: got pass=%0d fail=%0d expected 0 0", pass_cnt, fail_cnt);
    end
    checks++;
    if ({error, orphan_err, done, busy} !== 4'b0) begin
      failures++; $display("FAIL reset_flags: got %b expected 0000", {error, orphan_err, done, busy});
    end
`ifdef ALU_CHK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b0 || ff_exp !== '0 || ff_got !== '0 || ff_idx !== '0) begin
      failures++; $display("FAIL reset_ff: got v=%b e=%0d g=%0d i=%0d expected all 0", ff_valid, ff_exp, ff_got, ff_idx);
    end
`endif
  endtask

  task automatic test_single_pass();
    do_reset();
    set_vec(0, 3, 5, 0, 7'b0001000, 1'b0);
    run(1, 1'b0, 1'b0);
    checks++;
    if (pass_cnt !== 8'd1 || fail_cnt !== 8'd0 || error !== 1'b0) begin
      failures++; $display("FAIL single_pass: got pass=%0d fail=%0d err=%b expected 1 0 0", pass_cnt, fail_cnt, error);
    end
  endtask

  task automatic test_back_to_back();
    int a, b;
    do_reset();
    set_vec(0, 3, 5, 1, 7'b1111110, 1'b0);
    set_vec(1, 7'b1111111, 0, 2, 7'b1111111, 1'b0);
    set_vec(2, 7'b1000001, 0, 3, 7'b0000011, 1'b0);
    for (int i = 3; i < 6; i++) begin
      a = $urandom_range(0, 127); b = $urandom_range(0, 127);
      set_vec(i, a, b, 0, (a + b) & 127, 1'b0);
    end
    run(6, 1'b0, 1'b1);
    checks++;
    if (pass_cnt !== 8'd6 || done !== 1'b1) begin
      failures++; $display("FAIL b2b_final: got pass=%0d done=%b expected 6 1", pass_cnt, done);
    end
  endtask

  task automatic test_ignored_in_done();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; A = 7'($urandom); B = 7'($urandom); OP = 2'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1;
    checks++;
    if (pass_cnt !== 8'd6 || fail_cnt !== 8'd0 || error !== 1'b0 || orphan_err !== 1'b0 || done !== 1'b1) begin
      failures++; $display("FAIL ignored_in_done: got pass=%0d fail=%0d err=%b orph=%b done=%b expected 6 0 0 0 1",
                           pass_cnt, fail_cnt, error, orphan_err, done);
    end
  endtask

  task automatic test_mismatch();
    do_reset();
    set_vec(0, 3, 5, 0, 7'b0001001, 1'b0);
    run(1, 1'b0, 1'b0);
    checks++;
    if (fail_cnt !== 8'd1 || error !== 1'b1 || pass_cnt !== 8'd0) begin
      failures++; $display("FAIL mismatch: got fail=%0d err=%b pass=%0d expected 1 1 0", fail_cnt, error, pass_cnt);
    end
`ifdef ALU_CHK_FIRST_FAIL_EN
    checks++;
    if (ff_valid !== 1'b1 || ff_exp !== 7'b0001000 || ff_got !== 7'b0001001 || ff_idx !== 8'd0) begin
      failures++; $display("FAIL mismatch_ff: got v=%b e=%b g=%b i=%0d expected 1 0001000 0001001 0", ff_valid, ff_exp, ff_got, ff_idx);
    end
`endif
  endtask

  task automatic test_missing();
    do_reset();
    set_vec(0, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3), 0, 1'b1);
    run(1, 1'b0, 1'b0);
    checks++;
    if (fail_cnt !== 8'd1 || error !== 1'b1 || orphan_err !== 1'b0) begin
      failures++; $display("FAIL missing: got fail=%0d err=%b orph=%b expected 1 1 0", fail_cnt, error, orphan_err);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    res_valid = 1'b1; Y = 7'($urandom);
    @(posedge clk); #1;
    res_valid = 1'b0;
    checks++;
    if (orphan_err !== 1'b1 || error !== 1'b1 || pass_cnt !== '0 || fail_cnt !== '0) begin
      failures++; $display("FAIL orphan: got orph=%b err=%b pass=%0d fail=%0d expected 1 1 0 0", orphan_err, error, pass_cnt, fail_cnt);
    end
  endtask

  task automatic test_rst_midrun();
    do_reset();
    fill_random(3, 0);
    for (int t = 0; t <= LAT; t++) begin
      in_valid = (t < 3);
      if (t < 3) begin A = va[t]; B = vb[t]; OP = vop[t]; end
      res_valid = (t == LAT); Y = vgot[0];
      @(posedge clk); #1;
    end
    in_valid = 1'b0; res_valid = 1'b0;
    checks++;
    if (pass_cnt !== 8'd1 || busy !== 1'b1) begin
      failures++; $display("FAIL midrun_pre: got pass=%0d busy=%b expected 1 1", pass_cnt, busy);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (pass_cnt !== '0 || fail_cnt !== '0 || {error, orphan_err, done, busy} !== 4'b0) begin
      failures++; $display("FAIL midrun_rst: got pass=%0d fail=%0d flags=%b expected 0 0 0000",
                           pass_cnt, fail_cnt, {error, orphan_err, done, busy});
    end
    repeat (LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (fail_cnt !== '0 || error !== 1'b0 || orphan_err !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL midrun_flush: got fail=%0d err=%b orph=%b busy=%b expected 0 0 0 0", fail_cnt, error, orphan_err, busy);
    end
    m_pass = 0; m_fail = 0; m_err = 0; m_ffv = 0;
    fill_random(6, 0);
    run(6, 1'b1, 1'b0);
    checks++;
    if (pass_cnt !== 8'd6 || done !== 1'b1) begin
      failures++; $display("FAIL midrun_rerun: got pass=%0d done=%b expected 6 1", pass_cnt, done);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 5; k++) begin
      do_reset();
      fill_random(6, 40);
      run(6, 1'b1, 1'($urandom_range(0, 1)));
`ifdef ALU_CHK_FIRST_FAIL_EN
      checks++;
      if (ff_valid !== m_ffv || (m_ffv && (ff_exp !== 7'(m_ffe) || ff_got !== 7'(m_ffg) || ff_idx !== CW'(m_ffi)))) begin
        failures++; $display("FAIL random_ff run=%0d: got v=%b e=%0d g=%0d i=%0d expected v=%b e=%0d g=%0d i=%0d",
                             k, ff_valid, ff_exp, ff_got, ff_idx, m_ffv, m_ffe, m_ffg, m_ffi);
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_pass();
    test_back_to_back();
    test_ignored_in_done();
    test_mismatch();
    test_missing();
    test_orphan();
    test_rst_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
